seven_seg_scan: RTL

- Downstream consumer of the date/year digit source. Takes four BCD digits (num3..num0) and the date_year flag, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Contains a refresh prescaler, a digit-index counter and a frame-aligned shadow capture. The shadow capture prevents tearing when the upstream digits toggle mid-frame.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/bcd_to_seg.sv | 31 +++
 rtl/seven_seg_scan.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the seven-segment scanner.
//   - NUM_DIGITS      : digits on the display
//   - SEG_BLANK       : active-low pattern with every segment off
//   - SEG_DIGIT_0..9  : active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
//   - state_t         : scanner state encoding
//   - shadow_t        : frame-aligned copy of the input digits and mode flag
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h10;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SCAN  = 1'b1
  } state_t;

  typedef struct packed {
    logic       dy;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } shadow_t;

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD to seven-segment decoder, active-low output.
// Codes 10..15 decode to all segments off.
//   bcd : input  4-bit BCD digit
//   seg : output 7-bit active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_DIGIT_0;
      4'd1:    seg = SEG_DIGIT_1;
      4'd2:    seg = SEG_DIGIT_2;
      4'd3:    seg = SEG_DIGIT_3;
      4'd4:    seg = SEG_DIGIT_4;
      4'd5:    seg = SEG_DIGIT_5;
      4'd6:    seg = SEG_DIGIT_6;
      4'd7:    seg = SEG_DIGIT_7;
      4'd8:    seg = SEG_DIGIT_8;
      4'd9:    seg = SEG_DIGIT_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
// Time-multiplexes four BCD digits onto a 4-digit seven-segment display.
// Inputs are copied into a shadow only at frame boundaries, so upstream
// changes mid-frame never tear the displayed value.
//   clock      : input  system clock, rising edge
//   reset      : input  synchronous active-high reset
//   num3..num0 : input  BCD digits, num3 leftmost (an[3]), num0 rightmost
//   date_year  : input  0 = date mode (dp after digit 2), 1 = year mode
//   seg        : output segments {g,f,e,d,c,b,a}
//   dp         : output decimal point
//   an         : output digit enables, an[i] drives digit i
//   frame_done : output one-cycle pulse when a 4-digit frame completes
// Parameters:
//   REFRESH_DIV : cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  : 1 = active-low an/seg/dp, 0 = all three inverted
// -----------------------------------------------------------------------------
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] num3,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  input  logic       date_year,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int                 CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // XOR masks that flip the active-low internal encoding when the board
  // wants active-high drive.
  localparam logic [3:0] AN_POL  = {4{~ACTIVE_LOW}};
  localparam logic [6:0] SEG_POL = {7{~ACTIVE_LOW}};
  localparam logic       DP_POL  = ~ACTIVE_LOW;

  localparam logic [3:0] AN_OFF  = 4'hF ^ AN_POL;
  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ SEG_POL;
  localparam logic       DP_OFF  = 1'b1 ^ DP_POL;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  state_t           state;
  shadow_t          sh;

  logic             tick;
  state_t           nxt_state;
  logic [1:0]       nxt_idx;
  shadow_t          nxt_sh;
  logic             frame_end;
  logic [3:0]       nxt_digit;
  logic [6:0]       dec_seg;
  logic [3:0]       an_al;
  logic             dp_al;
  shadow_t          live;

  assign tick = (cnt == CNT_MAX);
  assign live = '{dy: date_year, d3: num3, d2: num2, d1: num1, d0: num0};

  // Next-state values are computed here so that the registered outputs can
  // be decoded from the digit and shadow that become current on this edge.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    nxt_state = state;
    nxt_idx   = idx;
    nxt_sh    = sh;
    frame_end = 1'b0;
    if (tick) begin
      if (state == S_BLANK) begin
        nxt_state = S_SCAN;
        nxt_idx   = 2'd0;
        nxt_sh    = live;
      end else if (idx == 2'd3) begin
        nxt_idx   = 2'd0;
        nxt_sh    = live;
        frame_end = 1'b1;
      end else begin
        nxt_idx   = idx + 2'd1;
      end
    end
  end

  always_comb begin
    nxt_digit = nxt_sh.d0;
    case (nxt_idx)
      2'd0: nxt_digit = nxt_sh.d0;
      2'd1: nxt_digit = nxt_sh.d1;
      2'd2: nxt_digit = nxt_sh.d2;
      2'd3: nxt_digit = nxt_sh.d3;
      default: nxt_digit = nxt_sh.d0;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (nxt_digit),
    .seg (dec_seg)
  );

  assign an_al = ~(4'b0001 << nxt_idx);
  // Decimal point separates day and month ("11.14"); never lit in year mode.
  assign dp_al = !((nxt_idx == 2'd2) && !nxt_sh.dy);

  always_ff @(posedge clock) begin
    // NOTE: the shadow is a handful of flops, not a memory, so it is reset
    // along with the rest of the state.
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      state      <= S_BLANK;
      sh         <= '0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      cnt        <= tick ? '0 : cnt + 1'b1;
      idx        <= nxt_idx;
      state      <= nxt_state;
      sh         <= nxt_sh;
      frame_done <= frame_end;
      if (nxt_state == S_SCAN) begin
        an  <= an_al ^ AN_POL;
        seg <= dec_seg ^ SEG_POL;
        dp  <= dp_al ^ DP_POL;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= DP_OFF;
      end
    end
  end

endmodule
